// File: rtl/ftdi_stream_pkg.sv
// ftdi_stream_pkg: shared state encoding and default burst/flush parameters for the FIFO-to-FTDI streamer.
package ftdi_stream_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;
  localparam int BURST_WORDS_DEF   = 1024;
  localparam int FLUSH_TIMEOUT_DEF = 4096;
endpackage

// File: rtl/ftdi_flush_timer.sv
// ftdi_flush_timer: saturating idle counter that flags the cycle on which TIMEOUT enabled cycles have elapsed.
module ftdi_flush_timer
  import ftdi_stream_pkg::*;
#(
  parameter int TIMEOUT = FLUSH_TIMEOUT_DEF,
  parameter int W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic expired
);
  logic [W-1:0] cnt_q, cnt_d;
  always_comb begin
    expired = (TIMEOUT != 0) && en && (cnt_q == W'(TIMEOUT - 1));
    cnt_d   = (clr || expired) ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/fifo_to_ftdi_burst_ctrl.sv
// fifo_to_ftdi_burst_ctrl: drains a FIFO into an FTDI port in fixed bursts, flushing partial data after an idle timeout.
module fifo_to_ftdi_burst_ctrl
  import ftdi_stream_pkg::*;
#(
  parameter int USEDW_W       = 11,
  parameter int BURST_WORDS   = BURST_WORDS_DEF,
  parameter int FLUSH_TIMEOUT = FLUSH_TIMEOUT_DEF,
  parameter int TO_W          = 16
) (
  input  logic               ftdi_clk,
  input  logic               ftdi_rst_n,
  input  logic [USEDW_W-1:0] fifo_usedw,
  input  logic               fifo_empty,
  input  logic               ftdi_rx_rdy,
  input  logic               err_clr,
  output logic               fifo_rdreq,
  output logic               fifo_tx_rdy,
  output logic               flush_active,
  output logic [USEDW_W-1:0] words_left,
  output logic               burst_done,
  output logic               underrun
);
  localparam logic [USEDW_W-1:0] BW = USEDW_W'(BURST_WORDS);
  state_e             state_q, state_d;
  logic [USEDW_W-1:0] left_q, left_d;
  logic               tx_q, tx_d, flush_q, flush_d, done_q, done_d, under_q, under_d;
  logic               full, idle, to_en, to_exp, under_set;
  ftdi_flush_timer #(
    .TIMEOUT(FLUSH_TIMEOUT),
    .W      (TO_W)
  ) u_timer (
    .clk    (ftdi_clk),
    .rst_n  (ftdi_rst_n),
    .en     (to_en),
    .clr    (!to_en),
    .expired(to_exp)
  );
  always_comb begin
    full       = fifo_usedw >= BW;
    idle       = state_q == ST_IDLE;
    to_en      = idle && !fifo_empty && !full;
    fifo_rdreq = tx_q && ftdi_rx_rdy && !fifo_empty;
    state_d    = state_q;
    left_d     = left_q;
    done_d     = 1'b0;
    under_set  = 1'b0;
    if (idle) begin
      if (full) begin
        state_d = ST_BURST;
        left_d  = BW;
      end else if (to_exp) begin
        state_d = ST_FLUSH;
        left_d  = fifo_usedw;
      end
    end else if (fifo_empty && left_q != '0) begin
      state_d   = ST_IDLE;
      left_d    = '0;
      under_set = 1'b1;
    end else if (fifo_rdreq) begin
      left_d  = (left_q == '0) ? '0 : left_q - 1'b1;
      state_d = (left_q <= USEDW_W'(1)) ? ST_IDLE : state_q;
      done_d  = left_q == USEDW_W'(1);
    end
    tx_d    = state_d != ST_IDLE;
    flush_d = state_d == ST_FLUSH;
    under_d = under_set || (under_q && !err_clr);
  end
  always_ff @(posedge ftdi_clk or negedge ftdi_rst_n) begin
    if (!ftdi_rst_n) begin
      state_q <= ST_IDLE;
      left_q  <= '0;
      tx_q    <= 1'b0;
      flush_q <= 1'b0;
      done_q  <= 1'b0;
      under_q <= 1'b0;
    end else begin
      state_q <= state_d;
      left_q  <= left_d;
      tx_q    <= tx_d;
      flush_q <= flush_d;
      done_q  <= done_d;
      under_q <= under_d;
    end
  end
  assign fifo_tx_rdy  = tx_q;
  assign flush_active = flush_q;
  assign words_left   = left_q;
  assign burst_done   = done_q;
  assign underrun     = under_q;
endmodule

// File: tb/tb_fifo_to_ftdi_burst_ctrl.sv
// tb_fifo_to_ftdi_burst_ctrl: randomized and directed checks against a transaction-level model of the burst controller.
module tb_fifo_to_ftdi_burst_ctrl;
  localparam int UW = 8, BW = 16, FT = 8;
  logic          clk = 0, rst_n = 1;
  logic [UW-1:0] usedw = '0;
  logic          empty = 1, rx = 0, clr = 0;
  logic          rdreq, tx_rdy, flush, done, under;
  logic [UW-1:0] wl;
  logic          nf_rdreq, nf_tx, nf_flush, nf_done, nf_under;
  logic [UW-1:0] nf_wl;
  int errors = 0, checks = 0;
  int level = 0, m_left = 0, m_idle = 0, n_rd = 0, n_done = 0, nf_busy = 0;
  bit m_xfer = 0, m_flush = 0, m_done = 0, m_under = 0;

  fifo_to_ftdi_burst_ctrl #(.USEDW_W(UW), .BURST_WORDS(BW), .FLUSH_TIMEOUT(FT), .TO_W(8)) dut (
    .ftdi_clk(clk), .ftdi_rst_n(rst_n), .fifo_usedw(usedw), .fifo_empty(empty),
    .ftdi_rx_rdy(rx), .err_clr(clr), .fifo_rdreq(rdreq), .fifo_tx_rdy(tx_rdy),
    .flush_active(flush), .words_left(wl), .burst_done(done), .underrun(under));

  fifo_to_ftdi_burst_ctrl #(.USEDW_W(UW), .BURST_WORDS(BW), .FLUSH_TIMEOUT(0), .TO_W(8)) dut_nf (
    .ftdi_clk(clk), .ftdi_rst_n(rst_n), .fifo_usedw(usedw), .fifo_empty(empty),
    .ftdi_rx_rdy(rx), .err_clr(clr), .fifo_rdreq(nf_rdreq), .fifo_tx_rdy(nf_tx),
    .flush_active(nf_flush), .words_left(nf_wl), .burst_done(nf_done), .underrun(nf_under));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs after the falling edge, compare against the model, then advance the model.
  task automatic tick(input bit rx_i, input bit fe, input bit clr_i, input int wr_pct);
    bit rd, set;
    @(negedge clk);
    usedw = UW'(level);
    empty = fe || level == 0;
    rx    = rx_i;
    clr   = clr_i;
    #1;
    rd = m_xfer && rx_i && !empty;
    chk("rdreq", rdreq, rd);
    chk("tx_rdy", tx_rdy, m_xfer);
    chk("flush_active", flush, m_flush);
    chk("words_left", wl, m_left);
    chk("burst_done", done, m_done);
    chk("underrun", under, m_under);
    n_rd    += rdreq;
    n_done  += done;
    nf_busy += nf_tx;
    set    = 0;
    m_done = 0;
    if (!m_xfer) begin
      if (level >= BW) begin
        m_xfer = 1; m_flush = 0; m_left = BW; m_idle = 0;
      end else if (empty) m_idle = 0;
      else begin
        m_idle++;
        if (m_idle == FT) begin
          m_xfer = 1; m_flush = 1; m_left = level; m_idle = 0;
        end
      end
    end else if (empty && m_left > 0) begin
      set = 1; m_xfer = 0; m_flush = 0; m_left = 0;
    end else if (rd) begin
      if (m_left == 1) begin
        m_done = 1; m_xfer = 0; m_flush = 0;
      end
      if (m_left > 0) m_left--;
    end
    if (set) m_under = 1;
    else if (clr_i) m_under = 0;
    if (rd && level > 0) level--;
    if ($urandom_range(99) < wr_pct && level < 255) level++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_tx_rdy", tx_rdy, 0);
    chk("rst_flush", flush, 0);
    chk("rst_words_left", wl, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", under, 0);
    chk("rst_rdreq", rdreq, 0);
    m_xfer = 0; m_flush = 0; m_done = 0; m_under = 0; m_left = 0; m_idle = 0;
    @(posedge clk);
    #1 rst_n = 1;
  endtask

  initial begin
    int wl_frz;
    do_reset();
    // partial data flushed after the idle timeout
    level = 5; n_rd = 0; n_done = 0;
    for (int i = 0; i < 30; i++) tick(1, 0, 0, 0);
    chk("flush_reads", n_rd, 5);
    chk("flush_done_pulses", n_done, 1);
    // full burst with a 100-cycle stall in the middle
    level = BW; n_rd = 0; n_done = 0;
    for (int i = 0; i < 50 && !(m_xfer && m_left == 10); i++) tick(1, 0, 0, 0);
    wl_frz = m_left;
    for (int i = 0; i < 100; i++) tick(0, 0, 0, 0);
    chk("stall_wl_frozen", wl, wl_frz);
    for (int i = 0; i < 50 && m_xfer; i++) tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("burst_reads", n_rd, BW);
    chk("burst_done_pulses", n_done, 1);
    chk("burst_wl_end", wl, 0);
    // underrun mid-burst, then clear
    level = BW; n_done = 0;
    for (int i = 0; i < 50 && !(m_xfer && m_left == 9); i++) tick(1, 0, 0, 0);
    tick(1, 1, 0, 0);
    tick(0, 1, 0, 0);
    chk("under_set", under, 1);
    chk("under_idle", tx_rdy, 0);
    chk("under_no_done", n_done, 0);
    tick(0, 1, 1, 0);
    tick(0, 1, 0, 0);
    chk("under_cleared", under, 0);
    // reset mid-burst, then a fresh burst
    level = BW;
    for (int i = 0; i < 50 && !(m_xfer && m_left == 8); i++) tick(1, 0, 0, 0);
    do_reset();
    level = BW; n_rd = 0; n_done = 0;
    for (int i = 0; i < 25; i++) tick(1, 0, 0, 0);
    chk("post_rst_reads", n_rd, BW);
    chk("post_rst_done", n_done, 1);
    // threshold reached on the cycle the timeout would fire
    do_reset();
    level = 3;
    for (int i = 0; i < FT - 1; i++) tick(1, 0, 0, 0);
    level = BW;
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    chk("tie_burst_tx", tx_rdy, 1);
    chk("tie_not_flush", flush, 0);
    // flush disabled: small backlog never moves on the FLUSH_TIMEOUT=0 instance
    for (int i = 0; i < 40; i++) tick(1, 0, 0, 0);
    do_reset();
    level = 3; nf_busy = 0;
    for (int i = 0; i < 10000; i++) tick(0, 0, 0, 0);
    chk("nf_no_transfer", nf_busy, 0);
    chk("nf_words_left", nf_wl, 0);
    // randomized traffic
    do_reset();
    level = 0;
    for (int i = 0; i < 4000; i++)
      tick($urandom_range(99) < 85, $urandom_range(99) < 2, $urandom_range(99) < 3,
           ((i / 500) % 2) ? 80 : 35);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_to_ftdi_burst_ctrl.md
FIFO_TO_FTDI_BURST_CTRL -- requirements
Module: fifo_to_ftdi_burst_ctrl

Interface
REQ-001 Parameter USEDW_W, default 11: width of the FIFO used-words count and of words_left.
REQ-002 Parameter BURST_WORDS, default 1024: words per full burst; SHALL satisfy 1 <= BURST_WORDS < 2**USEDW_W.
REQ-003 Parameter FLUSH_TIMEOUT, default 4096: idle cycles before a partial-burst flush; 0 disables flush.
REQ-004 Parameter TO_W, default 16: timeout counter width; SHALL satisfy FLUSH_TIMEOUT < 2**TO_W.
REQ-005 ftdi_clk  in  1  sole clock; all state changes on its rising edge.
REQ-006 ftdi_rst_n  in  1  asynchronous, active-low reset.
REQ-007 fifo_usedw  in  USEDW_W  FIFO read-side word count.
REQ-008 fifo_empty  in  1  FIFO empty flag.
REQ-009 ftdi_rx_rdy  in  1  FTDI side can accept a word this cycle.
REQ-010 err_clr  in  1  synchronous clear of underrun.
REQ-011 fifo_rdreq  out  1  FIFO read strobe (combinational).
REQ-012 fifo_tx_rdy  out  1  registered; high while a burst or flush is in progress.
REQ-013 flush_active  out  1  registered; high in FLUSH state only.
REQ-014 words_left  out  USEDW_W  registered; words remaining in the current transfer.
REQ-015 burst_done  out  1  one-cycle pulse after the last word of a burst or flush.
REQ-016 underrun  out  1  sticky error flag.

Function
REQ-017 FSM states: IDLE, BURST, FLUSH. fifo_tx_rdy = (state != IDLE). flush_active = (state == FLUSH).
REQ-018 fifo_rdreq = fifo_tx_rdy && ftdi_rx_rdy && !fifo_empty; each cycle with fifo_rdreq high is one accepted word.
REQ-019 IDLE -> BURST when fifo_usedw >= BURST_WORDS; words_left loads BURST_WORDS on the same edge. fifo_rdreq may assert in the first BURST cycle (1-cycle latency from the threshold).
REQ-020 Timeout counter: increments each IDLE cycle with !fifo_empty and fifo_usedw < BURST_WORDS. It clears on fifo_empty, on leaving IDLE, or on reaching the threshold. It saturates and does not wrap.
REQ-021 IDLE -> FLUSH when FLUSH_TIMEOUT != 0 and the counter equals FLUSH_TIMEOUT-1 with the increment condition true; words_left loads fifo_usedw sampled on that edge.
REQ-022 If the threshold and timeout conditions are true in the same cycle, BURST wins.
REQ-023 In BURST/FLUSH, words_left decrements by 1 per accepted word. An accepted word with words_left == 1 returns to IDLE; words_left becomes 0 and burst_done pulses on the next cycle.
REQ-024 ftdi_rx_rdy low stalls the transfer indefinitely. State and words_left hold, and no timeout counting occurs.
REQ-025 fifo_empty high in BURST/FLUSH with words_left > 0 sets underrun and aborts to IDLE next edge. words_left clears to 0 and burst_done does not pulse.
REQ-026 underrun clears only on err_clr, or on reset. If a set and err_clr occur in the same cycle, set wins.
REQ-027 fifo_usedw changes during BURST/FLUSH (concurrent writes) SHALL NOT alter words_left.
REQ-028 words_left never underflows. The decrement is blocked at 0.

Reset
REQ-029 While ftdi_rst_n is low: state = IDLE, timeout counter = 0, words_left = 0, fifo_tx_rdy = 0, flush_active = 0, burst_done = 0, underrun = 0; fifo_rdreq is therefore 0.
REQ-030 Reset asserted mid-burst abandons the transfer immediately (asynchronously), with no burst_done. Operation resumes from IDLE on the first edge after deassertion.

Structure
REQ-031 Shared package ftdi_stream_pkg holds the state encoding constants and the default values of BURST_WORDS and FLUSH_TIMEOUT.
REQ-032 One sub-module, ftdi_flush_timer, SHALL implement the parametrised saturating timeout counter (inputs: enable, clear; output: expired).

Verification
REQ-033 BURST_WORDS=1024; usedw rises to 1024, rx_rdy=1 -> tx_rdy high next cycle; exactly 1024 rdreq cycles; burst_done pulses once; words_left=0.
REQ-034 BURST_WORDS=16, FLUSH_TIMEOUT=8; usedw held at 5, not empty -> FLUSH entered after 8 cycles; 5 reads; burst_done pulses; flush_active low afterward.
REQ-035 Mid-burst, rx_rdy low for 100 cycles -> rdreq low, words_left frozen; resumes and completes the exact remaining count.
REQ-036 fifo_empty forced high at words_left=300 -> underrun=1, state IDLE, no burst_done; err_clr pulse -> underrun=0.
REQ-037 ftdi_rst_n pulsed low at words_left=512 -> all outputs 0 immediately; a new burst starts normally once usedw >= BURST_WORDS.
REQ-038 FLUSH_TIMEOUT=0, usedw=3 for 10000 cycles -> no transfer; usedw reaches BURST_WORDS in the same cycle the timeout would fire (FLUSH_TIMEOUT=8) -> BURST chosen.
